// File: rtl/uart_term_pkg.sv
// Shared definitions for the UART line responder.
// ASCII control/letter constants and the responder FSM state type.
package uart_term_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_BS = 8'h08;
    localparam logic [7:0] ASCII_a  = 8'h61;
    localparam logic [7:0] ASCII_z  = 8'h7A;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ECHO,
        ST_LF1,
        ST_HI,
        ST_LO,
        ST_CR2,
        ST_LF2,
        ST_GAP
    } state_t;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit value to uppercase ASCII hex digit.
// Ports: i_nibble (4b value in), o_char (8b ASCII '0'-'9' / 'A'-'F').
module nibble_to_ascii (
    input  logic [3:0] i_nibble,
    output logic [7:0] o_char
);

    logic [7:0] w_wide;

    assign w_wide = {4'h0, i_nibble};
    assign o_char = (i_nibble < 4'd10) ? (8'h30 + w_wide)
                                       : (8'h37 + w_wide);

endmodule

// File: rtl/uart_line_responder.sv
// Drains the UART rx FIFO, echoes each byte to the tx FIFO and, on CR,
// appends a two-digit hex line-length report framed by LF / CR LF.
// Ports: clk, reset_n (async, active-low);
//   rx side: r_data, rx_empty in, rd_uart pop pulse out;
//   tx side: w_data, wr_uart push pulse out, tx_full in;
//   status: last_char, line_len, byte_count (all registered).
module uart_line_responder
    import uart_term_pkg::*;
#(
    parameter bit         UPCASE  = 1'b1,
    parameter logic [7:0] LEN_MAX = 8'd255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  r_data,
    input  logic        rx_empty,
    output logic        rd_uart,
    output logic [7:0]  w_data,
    output logic        wr_uart,
    input  logic        tx_full,
    output logic [7:0]  last_char,
    output logic [7:0]  line_len,
    output logic [15:0] byte_count
);

    state_t      r_state;
    state_t      r_after;
    logic [7:0]  r_ch;
    logic        r_rd;
    logic        r_wr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_last;
    logic [7:0]  r_len;
    logic [15:0] r_cnt;

    logic        w_is_lower;
    logic [7:0]  w_echo;
    logic [7:0]  w_hi_chr;
    logic [7:0]  w_lo_chr;
    logic [7:0]  w_len_next;
    logic        w_is_wr;
    logic [7:0]  w_byte;
    state_t      w_next;

    nibble_to_ascii u_hi (
        .i_nibble (r_len[7:4]),
        .o_char   (w_hi_chr)
    );

    nibble_to_ascii u_lo (
        .i_nibble (r_len[3:0]),
        .o_char   (w_lo_chr)
    );

    assign w_is_lower = (r_ch >= ASCII_a) && (r_ch <= ASCII_z);
    assign w_echo     = (UPCASE && w_is_lower) ? (r_ch - 8'h20) : r_ch;

    always_comb begin
        w_len_next = r_len;
        if (r_ch == ASCII_BS) begin
            if (r_len != 8'd0) w_len_next = r_len - 8'd1;
        end else if (r_ch != ASCII_LF) begin
            if (r_len < LEN_MAX) w_len_next = r_len + 8'd1;
        end
    end

    // FETCH doubles as the first echo attempt so the echo can follow
    // the pop pulse with no dead cycle; ECHO is where it waits on tx_full.
    always_comb begin
        w_is_wr = 1'b1;
        w_byte  = 8'h00;
        w_next  = ST_IDLE;
        unique case (r_state)
            ST_FETCH, ST_ECHO: begin
                w_byte = w_echo;
                w_next = (r_ch == ASCII_CR) ? ST_LF1 : ST_IDLE;
            end
            ST_LF1: begin w_byte = ASCII_LF; w_next = ST_HI;  end
            ST_HI:  begin w_byte = w_hi_chr; w_next = ST_LO;  end
            ST_LO:  begin w_byte = w_lo_chr; w_next = ST_CR2; end
            ST_CR2: begin w_byte = ASCII_CR; w_next = ST_LF2; end
            ST_LF2: begin w_byte = ASCII_LF; w_next = ST_IDLE; end
            default: w_is_wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_after <= ST_IDLE;
            r_ch    <= 8'h00;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_wdata <= 8'h00;
            r_last  <= 8'h00;
            r_len   <= 8'h00;
            r_cnt   <= 16'h0000;
        end else begin
            r_rd <= 1'b0;
            r_wr <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (!rx_empty) begin
                    r_rd    <= 1'b1;
                    r_ch    <= r_data;
                    r_last  <= r_data;
                    r_cnt   <= r_cnt + 16'd1;
                    r_state <= ST_FETCH;
                end
            end else if (r_state == ST_GAP) begin
                r_state <= r_after;
            end else if (w_is_wr && !tx_full) begin
                r_wr    <= 1'b1;
                r_wdata <= w_byte;
                r_after <= w_next;
                r_state <= ST_GAP;
                if ((r_state == ST_FETCH || r_state == ST_ECHO)
                    && r_ch != ASCII_CR)
                    r_len <= w_len_next;
                if (r_state == ST_LF2)
                    r_len <= 8'h00;
            end else if (r_state == ST_FETCH) begin
                r_state <= ST_ECHO;
            end else if (!w_is_wr) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign rd_uart    = r_rd;
    assign wr_uart    = r_wr;
    assign w_data     = r_wdata;
    assign last_char  = r_last;
    assign line_len   = r_len;
    assign byte_count = r_cnt;

endmodule
